fb_pixel_reader: RTL and testbench
==================================

Name: fb_pixel_reader

Overview:
- Downstream of the VGA display counter: consumes its pixel position, active and sync outputs each `clk`.
- Fetches the matching pixel from a double-buffered frame buffer (RGB332, downscaled by 2^SCALE_SH) and expands it to 12-bit RGB.
- Delays hsync/vsync/active to stay aligned with the colour.
- Manages front/back buffer swap at frame boundaries for the upstream writer.

Parameters:
- FB_W, 160, frame buffer width in stored pixels
- FB_H, 120, frame buffer height in stored pixels
- SCALE_SH, 2, right-shift applied to pos_x/pos_y (each stored pixel covers 2^SCALE_SH x 2^SCALE_SH screen pixels)
- ADDR_W, 16, frame buffer address width; must hold 2*FB_W*FB_H
- RD_LAT, 1, memory read latency in cycles, rd_en to valid rd_data (1..4)
- BORDER_RGB, 12'h000, {r,g,b} driven when active but outside the stored image

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- i_pos_x  in  10  visible-area x from display counter
- i_pos_y  in  10  visible-area y from display counter
- i_active  in  1  visible-area flag
- i_hsync  in  1  horizontal sync, active-high
- i_vsync  in  1  vertical sync, active-high
- swap_req  in  1  writer has finished back buffer; request swap (pulse or level)
- rd_en  out  1  frame buffer read strobe
- rd_addr  out  ADDR_W  frame buffer read address
- rd_data  in  8  RGB332 pixel, valid RD_LAT cycles after rd_en
- o_r, o_g, o_b  out  4 each  pixel colour
- o_hsync, o_vsync, o_active  out  1 each  syncs/active aligned with colour
- disp_sel  out  1  buffer being displayed (0: base 0, 1: base FB_W*FB_H); writer uses ~disp_sel
- swap_ack  out  1  one-cycle pulse when a swap takes effect
- frame_start  out  1  one-cycle pulse on i_vsync rising edge

Behaviour:
- Reset: all outputs 0, delay pipelines cleared to 0, disp_sel=0, swap pending flag=0, vsync edge register=0.
- Stage A (cycle n+1):
  - sx = i_pos_x>>SCALE_SH, sy = i_pos_y>>SCALE_SH.
  - in_img = i_active & (sx<FB_W) & (sy<FB_H).
  - rd_en = in_img.
  - rd_addr = disp_sel*FB_W*FB_H + sy*FB_W + sx, truncated to ADDR_W. Multiply by constant FB_W, no overflow for legal parameters.
  - rd_addr holds its previous value when rd_en=0.
- Data stage (cycle n+1+RD_LAT): rd_data sampled.
- Output stage (cycle n+2+RD_LAT):
  - if delayed in_img: o_r={R[2:0],R[2]}, o_g={G[2:0],G[2]}, o_b={B[1:0],B[1:0]}, where rd_data = RRRGGGBB.
  - else if delayed i_active: BORDER_RGB.
  - else 12'h000.
- Total latency input -> o_* = RD_LAT+2 cycles. o_hsync, o_vsync, o_active are the inputs delayed by exactly RD_LAT+2 shift-register stages.
- Frame boundary = i_vsync=1 while registered previous i_vsync=0. frame_start pulses on the cycle after the boundary is sampled.
- Swap FSM, states IDLE and PENDING:
  - swap_req=1 in IDLE -> PENDING.
  - At a frame boundary in PENDING, or with swap_req=1 on the boundary cycle itself: toggle disp_sel, pulse swap_ack (same cycle as frame_start), return to IDLE.
  - swap_req held high across multiple boundaries: one swap per boundary.
  - swap_req while PENDING has no additional effect.
- disp_sel changes only at frame boundaries, never mid-frame. Reads in flight across a swap complete with the old base.
- rst asserted mid-frame: immediate return to reset state next cycle. Outputs stay black/deasserted until the pipeline refills (RD_LAT+2 cycles after rst drops).

Test Plan:
- Address map: SCALE_SH=2, disp_sel=0, i_active=1, pos (4,8) -> rd_en=1, rd_addr=321 one cycle later. After swap, same pos -> rd_addr=19521.
- Colour/latency: RD_LAT=1, rd_data=8'hE3 for pos (0,0) -> 3 cycles after input: o_r=4'hF, o_g=4'h0, o_b=4'hF, o_active=1.
- Blanking/border: i_active=0 -> rd_en=0 and RGB=000. FB_W=100, pos_x=420 active -> rd_en=0, RGB=BORDER_RGB.
- Sync alignment: random hsync/vsync/active streams with RD_LAT=1..4 -> o_hsync/o_vsync/o_active equal inputs delayed RD_LAT+2 every cycle.
- Swap handshake:
  - swap_req pulse mid-frame -> disp_sel unchanged until next i_vsync rise, then toggles with one swap_ack pulse coincident with frame_start.
  - swap_req on the boundary cycle itself -> swap on that boundary.
- Reset mid-frame: assert rst for 1 cycle during active video with disp_sel=1 -> disp_sel=0, all outputs 0 next cycle, correct pixels resume RD_LAT+2 cycles later.

Source files
------------

// File: rtl/fb_pixel_reader_if.sv
// Frame buffer read port shared by the pixel reader and its memory.
// master: rd_en/rd_addr out, rd_data in; slave: the reverse.
interface fb_pixel_reader_if #(
   parameter int ADDR_W = 16
);
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_data;

   modport master (
      output rd_en,
      output rd_addr,
      input  rd_data
   );

   modport slave (
      input  rd_en,
      input  rd_addr,
      output rd_data
   );
endinterface

// File: rtl/fb_pixel_reader.sv
// Double-buffered RGB332 frame buffer reader feeding a VGA output.
// Ports: clk/rst, display counter in (i_pos_*, i_active, i_*sync),
// fb read bus (fb.master), RGB444 + delayed syncs out, swap handshake.
module fb_pixel_reader #(
   parameter int          FB_W       = 160,
   parameter int          FB_H       = 120,
   parameter int          SCALE_SH   = 2,
   parameter int          ADDR_W     = 16,
   parameter int          RD_LAT     = 1,
   parameter logic [11:0] BORDER_RGB = 12'h000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [9:0]                i_pos_x,
   input  logic [9:0]                i_pos_y,
   input  logic                      i_active,
   input  logic                      i_hsync,
   input  logic                      i_vsync,
   input  logic                      swap_req,
   fb_pixel_reader_if.master         fb,
   output logic [3:0]                o_r,
   output logic [3:0]                o_g,
   output logic [3:0]                o_b,
   output logic                      o_hsync,
   output logic                      o_vsync,
   output logic                      o_active,
   output logic                      disp_sel,
   output logic                      swap_ack,
   output logic                      frame_start
);

   // Stage A register plus RD_LAT alignment stages
   localparam int DEPTH = RD_LAT + 1;

   localparam logic [ADDR_W-1:0] BASE1 = ADDR_W'(FB_W * FB_H);
   localparam logic [ADDR_W-1:0] FBW_A = ADDR_W'(FB_W);

   typedef enum logic {
      IDLE,
      PENDING
   } state_t;

   typedef struct packed {
      logic img;
      logic act;
      logic hs;
      logic vs;
   } tag_t;

   state_t            state;
   state_t            state_nx;
   logic              vs_q;
   logic              boundary;
   logic              do_swap;

   logic [9:0]        sx;
   logic [9:0]        sy;
   logic              in_img;
   logic [ADDR_W-1:0] addr_nx;
   logic [ADDR_W-1:0] addr_q;

   tag_t              pipe [DEPTH];
   tag_t              tail;
   logic [7:0]        pix;
   logic [11:0]       rgb_nx;

   // ------------------------------------------------------------
   // Stage A: scale, bounds check and address generation
   // ------------------------------------------------------------
   assign sx = i_pos_x >> SCALE_SH;
   assign sy = i_pos_y >> SCALE_SH;

   assign in_img = i_active
                 && (int'(sx) < FB_W)
                 && (int'(sy) < FB_H);

   assign addr_nx = (disp_sel ? BASE1 : '0)
                  + ADDR_W'(sy) * FBW_A
                  + ADDR_W'(sx);

   // Address holds between reads so the bus stays quiet off-image
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
      end else if (in_img) begin
         addr_q <= addr_nx;
      end
   end

   assign fb.rd_en   = pipe[0].img;
   assign fb.rd_addr = addr_q;

   // ------------------------------------------------------------
   // Tag pipeline: carries in_img and the raw timing signals so
   // they line up with rd_data at the last stage
   // ------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pipe[i] <= '0;
         end
      end else begin
         pipe[0] <= {in_img, i_active, i_hsync, i_vsync};
         for (int i = 1; i < DEPTH; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign tail = pipe[DEPTH-1];
   assign pix  = fb.rd_data;

   // ------------------------------------------------------------
   // Output stage: RGB332 -> RGB444 by repeating the top bits
   // ------------------------------------------------------------
   always_comb begin
      rgb_nx = 12'h000;
      if (tail.img) begin
         rgb_nx = {pix[7:5], pix[7],
                   pix[4:2], pix[4],
                   pix[1:0], pix[1:0]};
      end else if (tail.act) begin
         rgb_nx = BORDER_RGB;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_r      <= '0;
         o_g      <= '0;
         o_b      <= '0;
         o_hsync  <= 1'b0;
         o_vsync  <= 1'b0;
         o_active <= 1'b0;
      end else begin
         {o_r, o_g, o_b} <= rgb_nx;
         o_hsync  <= tail.hs;
         o_vsync  <= tail.vs;
         o_active <= tail.act;
      end
   end

   // ------------------------------------------------------------
   // Buffer swap control
   // ------------------------------------------------------------
   assign boundary = i_vsync & ~vs_q;

   // A request arriving on the boundary cycle itself swaps at once
   always_comb begin
      state_nx = state;
      do_swap  = 1'b0;
      case (state)
         IDLE: begin
            if (swap_req && boundary) begin
               do_swap = 1'b1;
            end else if (swap_req) begin
               state_nx = PENDING;
            end
         end
         PENDING: begin
            if (boundary) begin
               do_swap  = 1'b1;
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         vs_q        <= 1'b0;
         disp_sel    <= 1'b0;
         swap_ack    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         state       <= state_nx;
         vs_q        <= i_vsync;
         swap_ack    <= do_swap;
         frame_start <= boundary;
         if (do_swap) begin
            disp_sel <= ~disp_sel;
         end
      end
   end

endmodule

// File: tb/tb_fb_pixel_reader.sv
// Scoreboard bench: two reader configurations share one stimulus
// stream; a reference model predicts every output cycle.
module tb_fb_pixel_reader;

   typedef struct {
      int          due;
      logic [11:0] rgb;
      logic [2:0]  syn;
   } pix_t;

   typedef struct {
      int          due;
      logic        en;
      logic [15:0] addr;
      logic [2:0]  sw;
   } ctl_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] pos_x = '0;
   logic [9:0] pos_y = '0;
   logic       act = 1'b0;
   logic       hs = 1'b0;
   logic       vs = 1'b0;
   logic       req = 1'b0;

   logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
   logic       hs_a, vs_a, ac_a, ds_a, ak_a, fs_a;
   logic       hs_b, vs_b, ac_b, ds_b, ak_b, fs_b;

   int cyc = 0;
   int errors = 0;
   int checks = 0;

   pix_t pq0[$];
   pix_t pq1[$];
   ctl_t cq0[$];
   ctl_t cq1[$];

   bit          disp_m [2];
   bit          pend_m [2];
   bit          prev_m [2];
   logic [15:0] last_m [2];

   logic [7:0] ma [4];
   logic [7:0] mb [4];

   fb_pixel_reader_if #(.ADDR_W(16)) bus_a ();
   fb_pixel_reader_if #(.ADDR_W(16)) bus_b ();

   fb_pixel_reader #(
      .FB_W(160), .FB_H(120), .SCALE_SH(2), .ADDR_W(16),
      .RD_LAT(1), .BORDER_RGB(12'h000)
   ) dut_a (
      .clk(clk), .rst(rst),
      .i_pos_x(pos_x), .i_pos_y(pos_y),
      .i_active(act), .i_hsync(hs), .i_vsync(vs),
      .swap_req(req), .fb(bus_a),
      .o_r(r_a), .o_g(g_a), .o_b(b_a),
      .o_hsync(hs_a), .o_vsync(vs_a), .o_active(ac_a),
      .disp_sel(ds_a), .swap_ack(ak_a), .frame_start(fs_a)
   );

   fb_pixel_reader #(
      .FB_W(100), .FB_H(120), .SCALE_SH(2), .ADDR_W(16),
      .RD_LAT(4), .BORDER_RGB(12'h5A3)
   ) dut_b (
      .clk(clk), .rst(rst),
      .i_pos_x(pos_x), .i_pos_y(pos_y),
      .i_active(act), .i_hsync(hs), .i_vsync(vs),
      .swap_req(req), .fb(bus_b),
      .o_r(r_b), .o_g(g_b), .o_b(b_b),
      .o_hsync(hs_b), .o_vsync(vs_b), .o_active(ac_b),
      .disp_sel(ds_b), .swap_ack(ak_b), .frame_start(fs_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory contents are a fixed function of address; address 0
   // holds 8'hE3. Unread cycles return a poison value.
   function automatic logic [7:0] memf(input logic [15:0] a);
      logic [15:0] t;
      t = a * 16'd37 + 16'd227;
      return t[7:0];
   endfunction

   function automatic logic [11:0] expand(input logic [7:0] d);
      return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
   endfunction

   always @(posedge clk) begin
      ma[0] <= bus_a.rd_en ? memf(bus_a.rd_addr) : 8'hA5;
      mb[0] <= bus_b.rd_en ? memf(bus_b.rd_addr) : 8'hA5;
      for (int k = 1; k < 4; k++) begin
         ma[k] <= ma[k-1];
         mb[k] <= mb[k-1];
      end
   end

   assign bus_a.rd_data = ma[0];
   assign bus_b.rd_data = mb[3];

   // Reference model: output at cycle t reflects input at t-(L+2)
   // unless reset hit any cycle in between, in which case all zero.
   task automatic model(input int k, input bit r,
                        input int x, input int y,
                        input bit a, input bit h,
                        input bit v, input bit q);
      int          fbw;
      int          lat;
      logic [11:0] brd;
      int          sx, sy, addr;
      bit          in, bnd, sw;
      pix_t        p;
      ctl_t        c;
      fbw = (k == 0) ? 160 : 100;
      lat = (k == 0) ? 1 : 4;
      brd = (k == 0) ? 12'h000 : 12'h5A3;
      if (r) begin
         if (k == 0) begin
            for (int i = 0; i < pq0.size(); i++)
               if (pq0[i].due > cyc) begin
                  pq0[i].rgb = '0;
                  pq0[i].syn = '0;
               end
         end else begin
            for (int i = 0; i < pq1.size(); i++)
               if (pq1[i].due > cyc) begin
                  pq1[i].rgb = '0;
                  pq1[i].syn = '0;
               end
         end
         p = '{cyc + lat + 2, 12'h000, 3'b000};
         c = '{cyc + 1, 1'b0, 16'h0000, 3'b000};
         disp_m[k] = 0;
         pend_m[k] = 0;
         prev_m[k] = 0;
         last_m[k] = '0;
      end else begin
         sx = x >> 2;
         sy = y >> 2;
         in = a && (sx < fbw) && (sy < 120);
         addr = (disp_m[k] ? fbw * 120 : 0) + sy * fbw + sx;
         if (in) last_m[k] = 16'(addr);
         bnd = v && !prev_m[k];
         sw = bnd && (pend_m[k] || q);
         p.due = cyc + lat + 2;
         p.rgb = in ? expand(memf(16'(addr))) : (a ? brd : 12'h000);
         p.syn = {h, v, a};
         c = '{cyc + 1, in, last_m[k],
               {disp_m[k] ^ sw, sw, bnd}};
         prev_m[k] = v;
         if (sw) begin
            disp_m[k] = !disp_m[k];
            pend_m[k] = 0;
         end else if (q) begin
            pend_m[k] = 1;
         end
      end
      if (k == 0) begin
         pq0.push_back(p);
         cq0.push_back(c);
      end else begin
         pq1.push_back(p);
         cq1.push_back(c);
      end
   endtask

   task automatic step(input bit r, input int x, input int y,
                       input bit a, input bit h,
                       input bit v, input bit q);
      @(posedge clk);
      #1;
      rst = r;
      pos_x = 10'(x);
      pos_y = 10'(y);
      act = a;
      hs = h;
      vs = v;
      req = q;
      model(0, r, x, y, a, h, v, q);
      model(1, r, x, y, a, h, v, q);
   endtask

   task automatic chk(input string nm, input int k,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s dut%0d cyc=%0d got=%0h expected=%0h",
                  nm, k, cyc, got, exp);
      end
   endtask

   // Monitor: compare whenever a prediction falls due
   always @(negedge clk) begin
      pix_t p;
      ctl_t c;
      if (pq0.size() != 0 && pq0[0].due == cyc) begin
         p = pq0.pop_front();
         chk("rgb", 0, 32'({r_a, g_a, b_a}), 32'(p.rgb));
         chk("sync", 0, 32'({hs_a, vs_a, ac_a}), 32'(p.syn));
      end
      if (pq1.size() != 0 && pq1[0].due == cyc) begin
         p = pq1.pop_front();
         chk("rgb", 1, 32'({r_b, g_b, b_b}), 32'(p.rgb));
         chk("sync", 1, 32'({hs_b, vs_b, ac_b}), 32'(p.syn));
      end
      if (cq0.size() != 0 && cq0[0].due == cyc) begin
         c = cq0.pop_front();
         chk("rd_en", 0, 32'(bus_a.rd_en), 32'(c.en));
         chk("rd_addr", 0, 32'(bus_a.rd_addr), 32'(c.addr));
         chk("swap", 0, 32'({ds_a, ak_a, fs_a}), 32'(c.sw));
      end
      if (cq1.size() != 0 && cq1[0].due == cyc) begin
         c = cq1.pop_front();
         chk("rd_en", 1, 32'(bus_b.rd_en), 32'(c.en));
         chk("rd_addr", 1, 32'(bus_b.rd_addr), 32'(c.addr));
         chk("swap", 1, 32'({ds_b, ak_b, fs_b}), 32'(c.sw));
      end
   end

   initial begin
      bit h;
      bit v;
      repeat (3) step(1, 0, 0, 0, 0, 0, 0);
      // address map, colour, blanking, border
      step(0, 4, 8, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0);
      step(0, 420, 8, 1, 0, 0, 0);
      step(0, 10, 10, 0, 1, 0, 0);
      step(0, 639, 479, 1, 1, 0, 0);
      step(0, 12, 40, 1, 0, 0, 0);
      // mid-frame request, swap at next vsync rise
      step(0, 20, 20, 1, 0, 0, 1);
      repeat (5) step(0, 30, 30, 1, 0, 0, 0);
      repeat (4) step(0, 0, 0, 0, 0, 1, 0);
      repeat (2) step(0, 0, 0, 0, 0, 0, 0);
      step(0, 4, 8, 1, 0, 0, 0);
      step(0, 420, 8, 1, 0, 0, 0);
      // request on the boundary cycle itself
      step(0, 0, 0, 0, 0, 1, 1);
      repeat (3) step(0, 0, 0, 0, 0, 1, 0);
      step(0, 4, 8, 1, 0, 0, 0);
      // request held across two boundaries
      repeat (3) step(0, 8, 8, 1, 0, 0, 1);
      repeat (2) step(0, 0, 0, 0, 1, 1, 1);
      repeat (3) step(0, 8, 8, 1, 0, 0, 1);
      step(0, 0, 0, 0, 1, 1, 1);
      repeat (2) step(0, 0, 0, 0, 0, 1, 0);
      // get disp_sel=1, then reset mid-frame during video
      step(0, 40, 40, 1, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1, 0);
      repeat (2) step(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 16 * i, 36, 1, 0, 0, 0);
      step(1, 100, 36, 1, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 16 * i, 36, 1, 0, 0, 0);
      // randomized stream
      h = 0;
      v = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) h = !h;
         if ($urandom_range(0, 39) == 0) v = !v;
         step($urandom_range(0, 399) == 0,
              $urandom_range(0, 639), $urandom_range(0, 479),
              $urandom_range(0, 7) != 0, h, v,
              $urandom_range(0, 29) == 0);
      end
      repeat (10) step(0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
